// File: rtl/drum_voice_scheduler.sv
// Round-robin scheduler that maps latched drum-pad hits onto a pool of volume_shaper voices.
// Optional macro VOICE_STEAL_EN: with every voice busy, restart the oldest voice instead of waiting.
module drum_voice_scheduler #(
    parameter int NUM_PADS   = 8,
    parameter int NUM_VOICES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_PADS-1:0]      hit,
    input  logic                     cfg_we,
    input  logic [3:0]               cfg_pad,
    input  logic [2:0]               cfg_field,
    input  logic [7:0]               cfg_data,
    input  logic [NUM_VOICES-1:0]    voice_idle,
    output logic [NUM_VOICES-1:0]    voice_start,
    output logic [NUM_VOICES*40-1:0] voice_param,
    output logic [NUM_VOICES*4-1:0]  voice_pad,
    output logic [7:0]               drop_count
);
    localparam int          VW          = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [39:0] TABLE_RESET = 40'h0102_4001_FF;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_LOAD, S_START} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [NUM_PADS-1:0]   r_pend;
    logic [NUM_PADS-1:0]   w_pend_clr;
    logic [NUM_PADS-1:0]   w_drop;
    logic [4:0]            w_drop_n;
    logic [8:0]            w_drop_sum;
    logic [3:0]            r_rr;
    logic [39:0]           r_table [NUM_PADS];
    logic [39:0]           w_load_entry;
    logic [3:0]            r_cur_pad;
    logic [VW-1:0]         r_cur_voice;
    logic [NUM_VOICES-1:0] r_busy;
    logic [1:0]            r_holdoff [NUM_VOICES];
    logic [39:0]           r_param [NUM_VOICES];
    logic [3:0]            r_vpad [NUM_VOICES];
    logic [7:0]            r_drop;
    logic                  w_pad_found;
    logic [3:0]            w_sel_pad;
    logic                  w_voice_found;
    logic [VW-1:0]         w_sel_voice;
    logic                  w_dispatch;
`ifdef VOICE_STEAL_EN
    logic [7:0]            r_age [NUM_VOICES];
    logic [7:0]            w_best_age;
`endif

    // Round-robin pad pick: first pending pad at or after r_rr, wrapping.
    always_comb begin
        w_pad_found = 1'b0;
        w_sel_pad   = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                if (!w_pad_found && r_pend[p] &&
                    ((int'(r_rr) + i == p) || (int'(r_rr) + i == p + NUM_PADS))) begin
                    w_pad_found = 1'b1;
                    w_sel_pad   = 4'(p);
                end
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        w_voice_found = 1'b0;
        w_sel_voice   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!r_busy[v]) begin
                w_voice_found = 1'b1;
                w_sel_voice   = VW'(v);
            end
        end
`ifdef VOICE_STEAL_EN
        w_best_age = '0;
        if (!w_voice_found) begin
            w_voice_found = 1'b1;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (v == 0 || r_age[v] > w_best_age) begin
                    w_best_age  = r_age[v];
                    w_sel_voice = VW'(v);
                end
            end
        end
`endif
    end

    assign w_dispatch = (r_state == S_ARB) && w_pad_found && w_voice_found;

    always_comb begin
        w_pend_clr = '0;
        w_drop     = '0;
        w_drop_n   = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            w_pend_clr[p] = w_dispatch && (w_sel_pad == 4'(p));
            w_drop[p]     = hit[p] && r_pend[p] && !w_pend_clr[p];
            w_drop_n      = w_drop_n + {4'b0, w_drop[p]};
        end
        w_drop_sum = {1'b0, r_drop} + {4'b0, w_drop_n};
    end

    always_comb begin
        w_load_entry = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (r_cur_pad == 4'(p)) w_load_entry = r_table[p];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        voice_start  = '0;
        case (r_state)
            S_IDLE:  if (|r_pend) w_next_state = S_ARB;
            S_ARB:   if (w_dispatch) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_START;
            S_START: begin
                for (int v = 0; v < NUM_VOICES; v++) voice_start[v] = (r_cur_voice == VW'(v));
                w_next_state = (|r_pend) ? S_ARB : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // A hit in the same cycle as its pad's dispatch re-arms the pad.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_pend      <= '0;
            r_drop      <= '0;
            r_rr        <= '0;
            r_cur_pad   <= '0;
            r_cur_voice <= '0;
        end else begin
            r_pend <= (r_pend & ~w_pend_clr) | hit;
            r_drop <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
            if (w_dispatch) begin
                r_cur_pad   <= w_sel_pad;
                r_cur_voice <= w_sel_voice;
                r_rr        <= (w_sel_pad == 4'(NUM_PADS - 1)) ? 4'd0 : w_sel_pad + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the parameter table is reset explicitly, so it stays in flops rather than RAM.
            for (int p = 0; p < NUM_PADS; p++) r_table[p] <= TABLE_RESET;
        end else if (cfg_we) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                for (int f = 0; f < 5; f++) begin
                    if (cfg_pad == 4'(p) && cfg_field == 3'(f)) r_table[p][(4 - f) * 8 +: 8] <= cfg_data;
                end
            end
        end
    end

    // Holdoff masks the stale idle level the voice still shows just after its start pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_holdoff[v] <= '0;
                r_param[v]   <= '0;
                r_vpad[v]    <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (voice_start[v]) begin
                    r_busy[v]    <= 1'b1;
                    r_holdoff[v] <= 2'd2;
                end else if (r_holdoff[v] != 2'd0) begin
                    r_holdoff[v] <= r_holdoff[v] - 2'd1;
                end else if (r_busy[v] && voice_idle[v]) begin
                    r_busy[v] <= 1'b0;
                end
                if (r_state == S_LOAD && r_cur_voice == VW'(v)) begin
                    r_param[v] <= w_load_entry;
                    r_vpad[v]  <= r_cur_pad;
                end
            end
        end
    end

`ifdef VOICE_STEAL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VOICES; v++) r_age[v] <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (voice_start[v])                     r_age[v] <= '0;
                else if (r_busy[v] && r_age[v] != 8'hFF) r_age[v] <= r_age[v] + 8'd1;
            end
        end
    end
`endif

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
        assign voice_param[v*40 +: 40] = r_param[v];
        assign voice_pad[v*4 +: 4]     = r_vpad[v];
    end

    assign drop_count = r_drop;

endmodule

// File: tb/tb_drum_voice_scheduler.sv
// Directed, table-driven bench for drum_voice_scheduler with hand-written multi-cycle corner sequences.
module tb_drum_voice_scheduler;
    localparam int          NP  = 8;
    localparam int          NV  = 4;
    localparam logic [39:0] DEF = 40'h0102_4001_FF;
    localparam logic [39:0] P3A = 40'h1002_4001_FF;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    hit;
    logic             cfg_we;
    logic [3:0]       cfg_pad;
    logic [2:0]       cfg_field;
    logic [7:0]       cfg_data;
    logic [NV-1:0]    voice_idle;
    logic [NV-1:0]    voice_start;
    logic [NV*40-1:0] voice_param;
    logic [NV*4-1:0]  voice_pad;
    logic [7:0]       drop_count;

    int n_checks = 0;
    int n_errors = 0;

    drum_voice_scheduler #(.NUM_PADS(NP), .NUM_VOICES(NV)) dut (
        .clk         (clk),
        .reset       (reset),
        .hit         (hit),
        .cfg_we      (cfg_we),
        .cfg_pad     (cfg_pad),
        .cfg_field   (cfg_field),
        .cfg_data    (cfg_data),
        .voice_idle  (voice_idle),
        .voice_start (voice_start),
        .voice_param (voice_param),
        .voice_pad   (voice_pad),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  hit;
        logic        we;
        logic [3:0]  pad;
        logic [2:0]  field;
        logic [7:0]  data;
        logic [3:0]  exp_start;
        logic [15:0] exp_vpad;
        logic [7:0]  exp_drop;
        logic [39:0] exp_p0;
        logic [39:0] exp_p1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] h, input logic we, input logic [3:0] pad,
                                input logic [2:0] field, input logic [7:0] data,
                                input logic [3:0] st, input logic [15:0] vp, input logic [7:0] dr,
                                input logic [39:0] p0, input logic [39:0] p1);
        vec_t r;
        r.hit = h; r.we = we; r.pad = pad; r.field = field; r.data = data;
        r.exp_start = st; r.exp_vpad = vp; r.exp_drop = dr; r.exp_p0 = p0; r.exp_p1 = p1;
        return r;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; hit = '0; cfg_we = 1'b0; cfg_pad = '0; cfg_field = '0; cfg_data = '0;
        voice_idle = '1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_start(input string name, input logic [3:0] exp, input int budget);
        logic [3:0] got;
        got = '0;
        for (int k = 0; k < budget && got == '0; k++) begin
            step();
            got = voice_start;
        end
        check(name, got, exp);
        step();
        check({name, " one-cycle"}, voice_start, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] q[$];
        logic [3:0] fill_exp [4];
        int         n_starts;

        // Reset values observed while reset is held.
        reset = 1'b1; hit = '0; cfg_we = 1'b0; cfg_pad = '0; cfg_field = '0; cfg_data = '0;
        voice_idle = '1;
        #3;
        check("reset start", voice_start, 4'h0);
        check("reset param", voice_param, '0);
        check("reset pad",   voice_pad,   16'h0);
        check("reset drop",  drop_count,  8'h0);
        do_reset();

        // One vector per cycle: inputs held before edge i, outputs checked just after edge i.
        vecs.push_back(mk(8'h22, 0, 0, 0, 8'h00, 4'h0, 16'h0000, 0, 40'h0, 40'h0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h0, 16'h0000, 0, 40'h0, 40'h0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h0, 16'h0000, 0, 40'h0, 40'h0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h1, 16'h0001, 0, DEF, 40'h0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h0, 16'h0001, 0, DEF, 40'h0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h0, 16'h0001, 0, DEF, 40'h0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h2, 16'h0051, 0, DEF, DEF));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h0, 16'h0051, 0, DEF, DEF));
        vecs.push_back(mk(8'h08, 0, 0, 0, 8'h00, 4'h0, 16'h0051, 0, DEF, DEF));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h0, 16'h0051, 0, DEF, DEF));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h0, 16'h0051, 0, DEF, DEF));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h1, 16'h0053, 0, DEF, DEF));
        vecs.push_back(mk(8'h00, 1, 3, 0, 8'h10, 4'h0, 16'h0053, 0, DEF, DEF));
        vecs.push_back(mk(8'h00, 1, 9, 0, 8'h77, 4'h0, 16'h0053, 0, DEF, DEF));
        vecs.push_back(mk(8'h00, 1, 3, 5, 8'h77, 4'h0, 16'h0053, 0, DEF, DEF));
        vecs.push_back(mk(8'h08, 0, 0, 0, 8'h00, 4'h0, 16'h0053, 0, DEF, DEF));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h0, 16'h0053, 0, DEF, DEF));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h0, 16'h0053, 0, DEF, DEF));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h1, 16'h0053, 0, P3A, DEF));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h0, 16'h0053, 0, P3A, DEF));
        vecs.push_back(mk(8'h04, 0, 0, 0, 8'h00, 4'h0, 16'h0053, 0, P3A, DEF));
        vecs.push_back(mk(8'h04, 0, 0, 0, 8'h00, 4'h0, 16'h0053, 1, P3A, DEF));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h0, 16'h0053, 1, P3A, DEF));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h2, 16'h0023, 1, P3A, DEF));
        vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 4'h0, 16'h0023, 1, P3A, DEF));

        foreach (vecs[i]) begin
            hit = vecs[i].hit; cfg_we = vecs[i].we; cfg_pad = vecs[i].pad;
            cfg_field = vecs[i].field; cfg_data = vecs[i].data;
            step();
            check($sformatf("vec%0d start", i), voice_start, vecs[i].exp_start);
            check($sformatf("vec%0d pad", i), voice_pad, vecs[i].exp_vpad);
            check($sformatf("vec%0d drop", i), drop_count, vecs[i].exp_drop);
            check($sformatf("vec%0d param0", i), voice_param[39:0], vecs[i].exp_p0);
            check($sformatf("vec%0d param1", i), voice_param[79:40], vecs[i].exp_p1);
        end
        hit = '0; cfg_we = 1'b0;

        // Continuous hits on pad 2 with no voice ever going idle: drops saturate.
        do_reset();
        voice_idle = '0;
        hit = 8'h04;
        repeat (10) step();
        check("drop after 10 hits", drop_count, 8'd6);
        repeat (290) step();
        hit = '0;
        step();
        check("drop saturated", drop_count, 8'd255);

        // All voices busy, then a hit on pad 0.
        do_reset();
        voice_idle = '0;
        hit = 8'h0F;
        step();
        hit = '0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (voice_start != '0) q.push_back(voice_start);
        end
        fill_exp = '{4'h1, 4'h2, 4'h4, 4'h8};
        check("fill pulse count", q.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("fill pulse %0d", i), (i < q.size()) ? q[i] : 4'h0, fill_exp[i]);
        check("fill pads", voice_pad, 16'h3210);
        hit = 8'h01;
        step();
        hit = '0;
`ifdef VOICE_STEAL_EN
        wait_start("steal oldest", 4'h1, 10);
        check("steal pads", voice_pad, 16'h3210);
`else
        n_starts = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (voice_start != '0) n_starts++;
        end
        check("no start while busy", n_starts, 0);
        voice_idle = 4'b0100;
        wait_start("start on idle voice 2", 4'h4, 10);
        check("voice 2 pad", voice_pad, 16'h3010);
`endif

        // Reset asserted while the FSM is in S_LOAD.
        do_reset();
        hit = 8'h08;
        step();
        step();
        hit = '0;
        wait_start("pre-abort dispatch", 4'h1, 10);
        repeat (2) step();
        hit = 8'h08;
        step();
        hit = '0;
        step();
        step();
        check("load-state start", voice_start, 4'h0);
        check("load-state pad", voice_pad, 16'h0003);
        check("load-state drop", drop_count, 8'd1);
        reset = 1'b1;
        #1;
        check("abort start", voice_start, 4'h0);
        check("abort param", voice_param, '0);
        check("abort pad", voice_pad, 16'h0);
        check("abort drop", drop_count, 8'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_starts = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (voice_start != '0) n_starts++;
        end
        check("no start after abort", n_starts, 0);
        check("pad after abort", voice_pad, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
